uart_periph: RTL

UART_PERIPH -- requirements
Module: uart_periph

---
 rtl/uart_periph.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/uart_periph.sv
// Memory-mapped 8N1 UART: one transmit holding byte, one receive byte with
// valid/overrun/framing-error status, fixed BAUD_DIV clocks per bit.
module uart_periph #(
    parameter int unsigned BAUD_DIV = 5208
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx
);
    localparam logic [31:0] AddrTxd  = 32'h4000_0018;
    localparam logic [31:0] AddrRxd  = 32'h4000_001C;
    localparam logic [31:0] AddrStat = 32'h4000_0020;

    localparam int unsigned CntW = $clog2(BAUD_DIV);
    localparam logic [CntW-1:0] BitLast  = CntW'(BAUD_DIV - 1);
    localparam logic [CntW-1:0] HalfLast = CntW'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    tx_state_e       tx_state_q, tx_state_d;
    logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic            tx_line_q, tx_line_d;
    logic            tx_busy, tx_tick;

    rx_state_e       rx_state_q, rx_state_d;
    logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_valid_q, rx_valid_d;
    logic            overrun_q, overrun_d;
    logic            frame_err_q, frame_err_d;
    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    logic            rx_fall, stop_ok, stop_bad;
    logic            rd_rxd, rd_stat;

    // Only the low byte of a TXD write is transmitted.
    logic unused_wdata;
    assign unused_wdata = ^wdata[31:8];

    assign tx_busy = (tx_state_q != TxIdle);
    assign tx_tick = (tx_cnt_q == BitLast);
    assign uart_tx = tx_line_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_byte_d  = tx_byte_q;
        if (tx_state_q == TxIdle) begin
            if (wr && addr == AddrTxd) begin
                tx_state_d = TxStart;
                tx_cnt_d   = '0;
                tx_byte_d  = wdata[7:0];
            end
        end else begin
            tx_cnt_d = tx_tick ? '0 : tx_cnt_q + 1'b1;
        end
        if (tx_tick) begin
            unique case (tx_state_q)
                TxIdle:  ;
                TxStart: begin
                    tx_state_d = TxData;
                    tx_bit_d   = '0;
                end
                TxData: begin
                    if (tx_bit_q == 3'd7) tx_state_d = TxStop;
                    else                  tx_bit_d   = tx_bit_q + 1'b1;
                end
                TxStop:  tx_state_d = TxIdle;
            endcase
        end
        // Line is registered from next state so uart_tx never glitches.
        unique case (tx_state_d)
            TxStart: tx_line_d = 1'b0;
            TxData:  tx_line_d = tx_byte_d[tx_bit_d];
            default: tx_line_d = 1'b1;
        endcase
    end

    assign rx_fall = rx_prev_q & ~rx_sync_q;
    assign rd_rxd  = rd && (addr == AddrRxd);
    assign rd_stat = rd && (addr == AddrStat);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        stop_ok    = 1'b0;
        stop_bad   = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                if (rx_fall) begin
                    rx_state_d = RxStart;
                    rx_cnt_d   = '0;
                end
            end
            RxStart: begin
                rx_cnt_d = rx_cnt_q + 1'b1;
                if (rx_cnt_q == HalfLast) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RxIdle : RxData;
                end
            end
            RxData: begin
                rx_cnt_d = rx_cnt_q + 1'b1;
                if (rx_cnt_q == BitLast) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = RxStop;
                    else                  rx_bit_d   = rx_bit_q + 1'b1;
                end
            end
            RxStop: begin
                rx_cnt_d = rx_cnt_q + 1'b1;
                if (rx_cnt_q == BitLast) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RxIdle;
                    stop_ok    = rx_sync_q;
                    stop_bad   = ~rx_sync_q;
                end
            end
        endcase

        // A new byte wins over a coincident RXD read, which does not count as overrun.
        rx_data_d   = stop_ok ? rx_shift_q : rx_data_q;
        rx_valid_d  = stop_ok ? 1'b1 : (rd_rxd ? 1'b0 : rx_valid_q);
        overrun_d   = (stop_ok && rx_valid_q && !rd_rxd) ? 1'b1 :
                      (rd_stat ? 1'b0 : overrun_q);
        frame_err_d = stop_bad ? 1'b1 : (rd_stat ? 1'b0 : frame_err_q);
    end

    always_comb begin
        rdata = '0;
        if (rd_rxd) begin
            rdata[7:0] = rx_data_q;
        end else if (rd_stat) begin
            rdata[4:1] = {tx_busy, rx_valid_q, overrun_q, frame_err_q};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q  <= TxIdle;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_byte_q   <= '0;
            tx_line_q   <= 1'b1;
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            rx_state_q  <= RxIdle;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_byte_q   <= tx_byte_d;
            tx_line_q   <= tx_line_d;
            rx_meta_q   <= uart_rx;
            rx_sync_q   <= rx_meta_q;
            rx_prev_q   <= rx_sync_q;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end
endmodule
